// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
// The pointer increment wraps by explicit compare so any DEPTH works.
package fifo_pkg;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_t;

  // Modulo-depth increment; depth need not be a power of two.
  function automatic logic [31:0] ptr_next(input logic [31:0] ptr,
                                           input logic [31:0] depth);
    logic [31:0] nxt;
    if (ptr == depth - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the FIFO: one write port and one registered
// read port whose output holds whenever no read is requested.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 10,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // A read and write to the same slot in one cycle returns the old word,
  // which is what the full + read + write case relies on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, read-valid strobe,
// threshold flags and sticky overflow/underflow errors.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 10,
  parameter int AF_THRESH = 8,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow,
  output logic [1:0]                 state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  generate
    if (!((AE_THRESH > 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH < DEPTH))) begin : g_bad_params
      $error("param_sync_fifo: need 0 < AE_THRESH < AF_THRESH < DEPTH");
    end
  endgenerate

  // Handshake: a read is taken when rd_en is high and the registered state
  // is not EMPTY; a write is taken when wr_en is high and the FIFO is not
  // FULL, or is FULL but a read is taken in the same cycle. Both decisions
  // use registered state only, so no status output depends on wr_en/rd_en.

  fifo_state_t       state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              dv_q;
  logic              rd_acc, wr_acc;

  assign empty  = (state_q == FIFO_EMPTY);
  assign full   = (state_q == FIFO_FULL);
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FIFO_EMPTY;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr  <= wr_ptr_d;
      rd_ptr  <= rd_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      dv_q    <= rd_acc;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = PTR_W'(ptr_next(32'(wr_ptr), 32'(DEPTH)));
    end
    if (rd_acc) begin
      rd_ptr_d = PTR_W'(ptr_next(32'(rd_ptr), 32'(DEPTH)));
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FIFO_EMPTY: begin
        if (wr_acc) begin
          state_d = FIFO_PARTIAL;
        end
      end
      FIFO_PARTIAL: begin
        if (rd_acc && !wr_acc && (count_q == CNT_W'(1))) begin
          state_d = FIFO_EMPTY;
        end else if (wr_acc && !rd_acc && (count_q == CNT_W'(DEPTH - 1))) begin
          state_d = FIFO_FULL;
        end
      end
      FIFO_FULL: begin
        if (rd_acc && !wr_acc) begin
          state_d = FIFO_PARTIAL;
        end
      end
      default: state_d = FIFO_EMPTY;
    endcase
  end

  // A rejected request in the same cycle as clr_err leaves the flag set.
  always_comb begin
    ovf_d = clr_err ? 1'b0 : ovf_q;
    udf_d = clr_err ? 1'b0 : udf_q;
    if (wr_en && !wr_acc) begin
      ovf_d = 1'b1;
    end
    if (rd_en && !rd_acc) begin
      udf_d = 1'b1;
    end
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign dout_valid   = dv_q;
  assign state        = state_q;

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO: next generation of the fixed 8-bit, 10-entry buffer used across the vending datapath (coin/product queues).
- Generalised data width, depth and almost-full/almost-empty thresholds.
- Adds occupancy count, read-data valid strobe, same-cycle read/write when full, and sticky overflow/underflow error flags with synchronous clear.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 10, number of storage entries (>=2, need not be a power of two)
AF_THRESH, 8, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
Elaboration error unless 0 < AE_THRESH < AF_THRESH < DEPTH.
Derived localparams: PTR_W = clog2(DEPTH); CNT_W = clog2(DEPTH+1).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write request
din  in  DATA_W  write data
rd_en  in  1  read request
clr_err  in  1  synchronous clear of overflow/underflow
dout  out  DATA_W  registered read data
dout_valid  out  1  one-cycle pulse: dout updated this cycle
count  out  CNT_W  entries held, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset values:
  - state = EMPTY; wr_ptr = rd_ptr = 0; count = 0.
  - Storage all 0; dout = 0; dout_valid = 0.
  - overflow = underflow = 0.
  - Hence empty = 1, almost_empty = 1, full = 0, almost_full = 0.
- State register fifo_state_t:
  - EMPTY, PARTIAL, FULL, all flags decoded from registered state/count.
  - No combinational path from wr_en/rd_en to any status output.
- Acceptance, evaluated on registered state:
  - rd_acc = rd_en && !empty.
  - wr_acc = wr_en && (!full || rd_acc).
- Write: on wr_acc, mem[wr_ptr] <= din; wr_ptr advances, wrapping DEPTH-1 -> 0.
- Read:
  - On rd_acc, dout <= mem[rd_ptr] at the next edge; dout_valid = 1 for exactly that cycle; rd_ptr advances with the same wrap.
  - Read latency is 1 clock.
  - dout holds its value when no read is accepted.
- count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Transitions:
  - EMPTY -> PARTIAL on wr_acc.
  - PARTIAL -> EMPTY on rd_acc && !wr_acc && count==1.
  - PARTIAL -> FULL on wr_acc && !rd_acc && count==DEPTH-1.
  - FULL -> PARTIAL on rd_acc && !wr_acc.
  - All other cases: hold.
- Simultaneous events:
  - Empty + wr + rd: write accepted, read rejected, underflow set; the new word is not bypassed to dout.
  - Full + wr + rd: both accepted; the oldest word goes out and the new word enters the freed slot; count stays DEPTH; overflow not set.
- Errors:
  - overflow <= 1 on wr_en && !wr_acc.
  - underflow <= 1 on rd_en && !rd_acc.
  - clr_err clears both; a same-cycle set wins over the clear.
- Rejected operations do not alter pointers, count, storage or dout.
- Reset mid-operation returns everything to reset values immediately; stored data is discarded.
- Pointer arithmetic is explicit compare-to-DEPTH-1 wrap. There is no reliance on power-of-two rollover.

Decomposition:
- Package fifo_pkg:
  - typedef enum fifo_state_t {FIFO_EMPTY, FIFO_PARTIAL, FIFO_FULL}.
  - function ptr_next(ptr, depth) implementing the modulo-DEPTH increment.
- Sub-module fifo_mem:
  - DATA_W x DEPTH register array, asynchronous reset to 0.
  - One write port (we, waddr, wdata).
  - One registered read port (re, raddr -> rdata), holding rdata when re = 0.
  - param_sync_fifo owns state, pointers, count, flags and errors.

Test Plan:
1. Reset, then write 10 words 0x11..0x1A with DEPTH=10 -> count 1..10; almost_full first high when count = 8; full = 1 and state FULL after the 10th write; overflow stays 0.
2. From full, wr_en with din = 0x55 and no read -> write rejected, overflow = 1, count stays 10. Then clr_err -> overflow = 0.
3. From full, wr_en = rd_en = 1 with din = 0x2B -> dout = 0x11 with dout_valid one cycle later, count stays 10, full stays 1. Draining all entries returns 0x12..0x1A then 0x2B in order.
4. Wrap-around: write 7, read 7, write 6 (0xA0..0xA5), read 6 -> output matches input order across the pointer wrap at index 9 -> 0, count ends at 0, empty = 1.
5. Empty with rd_en = 1 -> underflow = 1, dout_valid = 0, dout unchanged. Empty with wr_en = rd_en = 1, din = 0x77 -> count = 1, underflow = 1, next read returns 0x77.
6. Assert rst with count = 5 mid-stream -> immediately count = 0, empty = 1, dout = 0, error flags 0. A subsequent read is rejected (underflow = 1).
